// File: rtl/wb_arb_if.sv
// Bus bundle for wb_arb: pipeline write-back request, LU result handshake and
// register-file write port. The slave modport is the arbiter's side.
interface wb_arb_if #(
    parameter int XLEN = 32
);
    logic            wb_valid_i;
    logic [4:0]      wb_rd_i;
    logic [1:0]      wb_src_i;
    logic [XLEN-1:0] wb_data_i;
    logic [1:0]      wb_sel1_o;
    logic [1:0]      wb_sel2_o;
    logic            lu_valid_i;
    logic            lu_ready_o;
    logic [4:0]      lu_rd_i;
    logic [XLEN-1:0] lu_data_i;
    logic            stall_o;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;

    modport slave (
        input  wb_valid_i, wb_rd_i, wb_src_i, wb_data_i,
        input  lu_valid_i, lu_rd_i, lu_data_i,
        output wb_sel1_o, wb_sel2_o, lu_ready_o, stall_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport master (
        output wb_valid_i, wb_rd_i, wb_src_i, wb_data_i,
        output lu_valid_i, lu_rd_i, lu_data_i,
        input  wb_sel1_o, wb_sel2_o, lu_ready_o, stall_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/wb_arb.sv
// Write-back select decode and register-file write-port arbiter (pipeline vs LU FIFO).
// Optional macro WB_ARB_BYPASS_EN: grant an LU result straight to the port when the FIFO is empty.
//
// state | meaning
// NORM  | pipeline has priority, FIFO head retires on idle port, wait_cnt tracks LU losses
// DRAIN | stall_o high for one cycle, FIFO head retires, pipeline re-presents next cycle
module wb_arb #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input logic      clk,
    input logic      rst,
    wb_arb_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT) + 1;

    localparam logic [0:0] S_NORM  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];

    logic pipe_req, fifo_empty, lu_ready, push, pop, bypass;

    assign pipe_req   = bus.wb_valid_i && (bus.wb_rd_i != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign lu_ready   = (count_q < CW'(DEPTH));

    assign bus.wb_sel1_o  = (bus.wb_src_i[0]) ? 2'b01 : 2'b00;
    assign bus.wb_sel2_o  = (bus.wb_src_i == 2'b10) ? 2'b01 : 2'b00;
    assign bus.lu_ready_o = lu_ready;
    assign bus.stall_o    = (state_q == S_DRAIN);
    assign bus.rf_we_o    = rf_we_q;
    assign bus.rf_waddr_o = rf_waddr_q;
    assign bus.rf_wdata_o = rf_wdata_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pop        = 1'b0;
        bypass     = 1'b0;
        rf_we_d    = 1'b0;
        rf_waddr_d = 5'd0;
        rf_wdata_d = '0;
        case (state_q)
            S_DRAIN: begin
                pop        = !fifo_empty;
                wait_cnt_d = '0;
                state_d    = S_NORM;
            end
            default: begin
                if (pipe_req) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = bus.wb_rd_i;
                    rf_wdata_d = bus.wb_data_i;
                    if (fifo_empty) begin
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == WW'(MAX_WAIT - 1)) begin
                        state_d    = S_DRAIN;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end
`ifdef WB_ARB_BYPASS_EN
                else if (fifo_empty && bus.lu_valid_i) begin
                    bypass     = 1'b1;
                    rf_we_d    = (bus.lu_rd_i != 5'd0);
                    rf_waddr_d = bus.lu_rd_i;
                    rf_wdata_d = bus.lu_data_i;
                    wait_cnt_d = '0;
                end
`endif
                else begin
                    pop        = !fifo_empty;
                    wait_cnt_d = '0;
                end
            end
        endcase
        if (pop) begin
            rf_we_d    = (fifo_rd_q[rd_ptr_q] != 5'd0);
            rf_waddr_d = fifo_rd_q[rd_ptr_q];
            rf_wdata_d = fifo_data_q[rd_ptr_q];
        end
    end

    // A bypassed result never enters the FIFO; a full FIFO refuses even with a pop.
    assign push = bus.lu_valid_i && lu_ready && !bypass;

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_NORM;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= bus.lu_rd_i;
            fifo_data_q[wr_ptr_q] <= bus.lu_data_i;
        end
    end
endmodule
